fp_sqrt_invsqrt_iter: RTL and testbench
=======================================

// Module: fp_sqrt_invsqrt_iter
// PURPOSE
// Parametrised iterative floating-point SQRT / inverse-SQRT unit; successor to the fixed-width
// sqrt wrapper. Handles full packed operands (sign, biased exponent, fraction) for any E_DW/F_DW.
// Uses a valid/ready handshake and an explicit FSM. Rounds to nearest-even.
// Handles IEEE special cases with exception flags. Sits beside the LAMP FPU datapath.
// PARAMETERS
// E_DW   8   exponent width; bias B = 2**(E_DW-1)-1
// F_DW   7   stored fraction width (hidden bit implied); ITER = F_DW+2 root bits (1 int, F_DW frac, 1 guard)
// PORTS
// clk        in   1     clock, all state on rising edge
// rst        in   1     synchronous, active-high reset
// valid_i    in   1     operand valid
// ready_o    out  1     unit can accept (high only in IDLE)
// inv_i      in   1     0 = sqrt(x), 1 = 1/sqrt(x); sampled on accept
// s_i        in   1     operand sign
// e_i        in   E_DW  operand biased exponent
// f_i        in   F_DW  operand fraction
// valid_o    out  1     result valid, held until ready_i
// ready_i    in   1     consumer accepts result
// s_o        out  1     result sign
// e_o        out  E_DW  result biased exponent
// f_o        out  F_DW  result fraction
// invalid_o  out  1     NaN produced (negative nonzero or NaN input); qualified by valid_o
// divzero_o  out  1     inv sqrt of +/-0; qualified by valid_o
// BEHAVIOUR
// - Reset: FSM=IDLE, ready_o=1, valid_o=0; s_o/e_o/f_o/flags = 0. A reset mid-operation aborts and discards the operation.
// - Accept: valid_i && ready_o at a rising edge. Operands and inv_i are registered, ready_o drops next cycle.
// - FSM states and transitions:
//   IDLE -> SPECIAL on accept if the operand is special; otherwise IDLE -> ROOT.
//   ROOT runs ITER cycles of restoring digit recurrence, one root bit per cycle, remainder kept.
//   ROOT -> DIV if inv, else ROOT -> ROUND.
//   DIV runs ITER cycles of restoring division 1/root, one quotient bit per cycle, then -> ROUND.
//   ROUND: 1 cycle, RNE using guard bit and sticky (remainder != 0) -> DONE.
//   SPECIAL: 1 cycle, loads the fixed result -> DONE.
//   DONE: valid_o=1; on ready_i -> IDLE.
// - Latency, accept edge to first valid_o cycle: sqrt ITER+2 (11 at default); inv 2*ITER+2 (20); special 2.
// - Throughput: next accept no earlier than the cycle after the output handshake (one IDLE bubble).
// - Outputs stable while valid_o && !ready_i. valid_o drops the cycle after the handshake.
// - Exponent path:
//   u = e_i - B. If u is odd, mantissa {1,f} is shifted left 1 and u -= 1.
//   sqrt: e_o = u/2 + B. Root lies in [1,2), so no renormalisation.
//   inv: q = 1/root lies in (0.5,1]. If q == 1 exactly, e_o = -u/2 + B; else shift q left 1 and e_o = -u/2 - 1 + B.
//   If rounding carries the mantissa to 2.0: fraction = 0, e_o += 1.
//   Overflow and underflow are impossible for normal inputs; no saturation logic is needed.
// - Special cases (subnormals, e_i == 0, are flushed to zero with the sign kept):
//   +/-0:    sqrt -> +/-0; inv -> +/-inf with divzero_o = 1.
//   +inf:    sqrt -> +inf; inv -> +0.
//   NaN, -inf, or negative nonzero: canonical qNaN (s=0, e=all ones, f=MSB only), invalid_o = 1.
// - A valid_i that arrives while busy is ignored (ready_o = 0); the producer must hold it.
// TESTING
// 1 sqrt(4.0): s=0 e=129 f=0x00 -> valid_o at accept+11: s=0 e=128 f=0x00, flags 0
// 2 sqrt(2.0): e=128 f=0 -> e=127 f=0x35 (RNE of 1.41421); inv(2.0) -> e=126 f=0x35 at accept+20
// 3 inv(4.0): e=129 f=0 -> e=126 f=0x00 at +20; inv(+0) -> e=255 f=0 divzero_o=1 at accept+2
// 4 sqrt(-1.0): s=1 e=127 -> s=0 e=255 f=0x40 invalid_o=1; sqrt(-0) -> s=1 e=0 f=0, flags 0
// 5 hold ready_i=0 for 5 cycles in DONE -> outputs constant, ready_o=0; valid_i pulsed meanwhile is ignored
// 6 rst during ROOT (cycle 4) -> next cycle valid_o=0 ready_o=1; a fresh sqrt(4.0) then completes in 11

Source files
------------

// File: rtl/fp_sqrt_invsqrt_iter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_sqrt_invsqrt_iter_if                                                      |
// | Operand/result handshake bundle for the iterative sqrt / inverse-sqrt unit. |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
interface fp_sqrt_invsqrt_iter_if #(
    parameter int E_DW = 8,
    parameter int F_DW = 7
);
    logic            valid_i;
    logic            ready_o;
    logic            inv_i;
    logic            s_i;
    logic [E_DW-1:0] e_i;
    logic [F_DW-1:0] f_i;
    logic            valid_o;
    logic            ready_i;
    logic            s_o;
    logic [E_DW-1:0] e_o;
    logic [F_DW-1:0] f_o;
    logic            invalid_o;
    logic            divzero_o;

    modport master (
        output valid_i, inv_i, s_i, e_i, f_i, ready_i,
        input  ready_o, valid_o, s_o, e_o, f_o, invalid_o, divzero_o
    );

    modport slave (
        input  valid_i, inv_i, s_i, e_i, f_i, ready_i,
        output ready_o, valid_o, s_o, e_o, f_o, invalid_o, divzero_o
    );
endinterface
`default_nettype wire

// File: rtl/fp_sqrt_invsqrt_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_sqrt_invsqrt_iter                                                         |
// | Iterative FP sqrt / 1/sqrt: restoring root, optional restoring 1/root, RNE.  |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module fp_sqrt_invsqrt_iter #(
    parameter int E_DW = 8,
    parameter int F_DW = 7
) (
    input  wire logic             clk,
    input  wire logic             rst,
    fp_sqrt_invsqrt_iter_if.slave bus
);
    localparam int ITER = F_DW + 2;
    localparam int RW   = ITER + 3;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [E_DW-1:0] BIAS     = {1'b0, {(E_DW-1){1'b1}}};
    localparam logic [E_DW-1:0] E_ONES   = {E_DW{1'b1}};
    localparam logic [F_DW-1:0] QNAN_F   = {1'b1, {(F_DW-1){1'b0}}};
    localparam logic [ITER-1:0] ONE_ROOT = {1'b1, {(ITER-1){1'b0}}};
    localparam logic [RW-1:0]   DIV_INIT = {3'b000, ONE_ROOT};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ROOT    = 3'd1,
        ST_DIV     = 3'd2,
        ST_ROUND   = 3'd3,
        ST_SPECIAL = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t            state;
    logic              ready;
    logic              valid;
    logic              res_s;
    logic [E_DW-1:0]   res_e;
    logic [F_DW-1:0]   res_f;
    logic              res_invalid;
    logic              res_divzero;

    logic              inv;
    logic              op_s;
    logic [E_DW-1:0]   op_e;
    logic [F_DW-1:0]   op_f;
    logic [E_DW-1:0]   half;
    logic [2*ITER-1:0] rad;
    logic [RW-1:0]     rem;
    logic [ITER-1:0]   root;
    logic [ITER-1:0]   quo;
    logic [CW-1:0]     cnt;

    // Accept-side decode: unbiased exponent, odd-exponent mantissa pre-shift.
    logic [E_DW:0]     u_raw;
    logic [F_DW+1:0]   mant_in;
    logic              special_in;
    always_comb begin
        u_raw      = {1'b0, bus.e_i} - {1'b0, BIAS};
        mant_in    = u_raw[0] ? {1'b1, bus.f_i, 1'b0} : {2'b01, bus.f_i};
        special_in = (bus.e_i == '0) | (&bus.e_i) | bus.s_i;
    end

    logic [RW-1:0] rem_sh, trial, div_sh, dvs;
    logic          root_ge, div_ge;
    always_comb begin
        rem_sh  = {rem[ITER:0], rad[2*ITER-1 -: 2]};
        trial   = {1'b0, root, 2'b01};
        root_ge = (rem_sh >= trial);
        div_sh  = {1'b0, rem[ITER:0], 1'b0};
        dvs     = {3'b000, root};
        div_ge  = (div_sh >= dvs);
    end

    // A truncated root of exactly 1.0 makes 1/root exact, so it bypasses the quotient.
    logic            one_root, sticky, round_up, carry;
    logic [ITER-1:0] sel;
    logic [F_DW:0]   mant, mant_rnd;
    logic [E_DW-1:0] e_base, e_res;
    always_comb begin
        one_root = (root == ONE_ROOT);
        sel      = root;
        sticky   = |rem;
        if (inv) begin
            if (one_root) begin
                sel    = ONE_ROOT;
                sticky = 1'b0;
            end else begin
                sel    = quo;
            end
        end
        mant     = sel[ITER-1:1];
        round_up = sel[0] & (sticky | mant[0]);
        mant_rnd = mant + {{F_DW{1'b0}}, round_up};
        carry    = ~mant_rnd[F_DW];
        if (inv) e_base = BIAS - half - {{(E_DW-1){1'b0}}, ~one_root};
        else     e_base = BIAS + half;
        e_res    = e_base + {{(E_DW-1){1'b0}}, carry};
    end

    logic            sp_s, sp_invalid, sp_divzero;
    logic [E_DW-1:0] sp_e;
    logic [F_DW-1:0] sp_f;
    logic            e_zero, bad_op;
    always_comb begin
        e_zero     = (op_e == '0);
        bad_op     = ((&op_e) & (op_f != '0)) | (op_s & ~e_zero);
        sp_s       = 1'b0;
        sp_e       = '0;
        sp_f       = '0;
        sp_invalid = 1'b0;
        sp_divzero = 1'b0;
        if (bad_op) begin
            sp_e       = E_ONES;
            sp_f       = QNAN_F;
            sp_invalid = 1'b1;
        end else if (e_zero) begin
            sp_s       = op_s;
            sp_e       = inv ? E_ONES : '0;
            sp_divzero = inv;
        end else begin
            sp_e       = inv ? '0 : E_ONES;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ready       <= 1'b1;
            valid       <= 1'b0;
            res_s       <= 1'b0;
            res_e       <= '0;
            res_f       <= '0;
            res_invalid <= 1'b0;
            res_divzero <= 1'b0;
            inv         <= 1'b0;
            op_s        <= 1'b0;
            op_e        <= '0;
            op_f        <= '0;
            half        <= '0;
            rad         <= '0;
            rem         <= '0;
            root        <= '0;
            quo         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.valid_i) begin
                        ready <= 1'b0;
                        inv   <= bus.inv_i;
                        op_s  <= bus.s_i;
                        op_e  <= bus.e_i;
                        op_f  <= bus.f_i;
                        half  <= u_raw[E_DW:1];
                        rad   <= {mant_in, {(F_DW+2){1'b0}}};
                        rem   <= '0;
                        root  <= '0;
                        quo   <= '0;
                        cnt   <= CW'(ITER - 1);
                        state <= special_in ? ST_SPECIAL : ST_ROOT;
                    end
                end
                ST_ROOT: begin
                    rad <= rad << 2;
                    if (root_ge) begin
                        rem  <= rem_sh - trial;
                        root <= {root[ITER-2:0], 1'b1};
                    end else begin
                        rem  <= rem_sh;
                        root <= {root[ITER-2:0], 1'b0};
                    end
                    if (cnt == '0) begin
                        if (inv) begin
                            rem   <= DIV_INIT;
                            cnt   <= CW'(ITER - 1);
                            state <= ST_DIV;
                        end else begin
                            state <= ST_ROUND;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    if (div_ge) begin
                        rem <= div_sh - dvs;
                        quo <= {quo[ITER-2:0], 1'b1};
                    end else begin
                        rem <= div_sh;
                        quo <= {quo[ITER-2:0], 1'b0};
                    end
                    if (cnt == '0) state <= ST_ROUND;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_ROUND: begin
                    res_s       <= op_s;
                    res_e       <= e_res;
                    res_f       <= mant_rnd[F_DW-1:0];
                    res_invalid <= 1'b0;
                    res_divzero <= 1'b0;
                    valid       <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_SPECIAL: begin
                    res_s       <= sp_s;
                    res_e       <= sp_e;
                    res_f       <= sp_f;
                    res_invalid <= sp_invalid;
                    res_divzero <= sp_divzero;
                    valid       <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.ready_i) begin
                        valid <= 1'b0;
                        ready <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o   = ready;
    assign bus.valid_o   = valid;
    assign bus.s_o       = res_s;
    assign bus.e_o       = res_e;
    assign bus.f_o       = res_f;
    assign bus.invalid_o = res_invalid;
    assign bus.divzero_o = res_divzero;
endmodule
`default_nettype wire

// File: tb/tb_fp_sqrt_invsqrt_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp_sqrt_invsqrt_iter                                                      |
// | Scoreboard bench: driver queues expected results, negedge monitor checks.    |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_fp_sqrt_invsqrt_iter;
    localparam int E_DW = 8;
    localparam int F_DW = 7;
    localparam int B    = 127;
    localparam int ITER = F_DW + 2;

    typedef struct {
        logic       s;
        logic [7:0] e;
        logic [6:0] f;
        logic       iv;
        logic       dz;
        int         lat;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   rand_rdy = 1'b1;
    bit   have = 1'b0;
    bit   drop_chk = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_sqrt_invsqrt_iter_if #(.E_DW(E_DW), .F_DW(F_DW)) bus ();
    fp_sqrt_invsqrt_iter #(.E_DW(E_DW), .F_DW(F_DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic exp_t mk(input logic s, input logic [7:0] e, input logic [6:0] f,
                                input logic iv, input logic dz, input int lat);
        exp_t r;
        r.s = s; r.e = e; r.f = f; r.iv = iv; r.dz = dz; r.lat = lat; r.acc = 0;
        return r;
    endfunction

    // Reference: integer square root of the scaled mantissa, then 1/root by plain division.
    function automatic exp_t model(input logic s, input logic [7:0] e, input logic [6:0] f, input logic inv);
        exp_t   r;
        int     u, m, ex, mant;
        longint n, rt, rm, sig, num;
        bit     st;
        r = mk(1'b0, 8'd0, 7'd0, 1'b0, 1'b0, 2);
        if ((e == 8'hFF && f != 0) || (s && e != 0)) begin
            r = mk(1'b0, 8'hFF, 7'h40, 1'b1, 1'b0, 2);
        end else if (e == 0) begin
            r = inv ? mk(s, 8'hFF, 7'd0, 1'b0, 1'b1, 2) : mk(s, 8'd0, 7'd0, 1'b0, 1'b0, 2);
        end else if (e == 8'hFF) begin
            r = inv ? mk(1'b0, 8'd0, 7'd0, 1'b0, 1'b0, 2) : mk(1'b0, 8'hFF, 7'd0, 1'b0, 1'b0, 2);
        end else begin
            u = int'(e) - B;
            m = (1 << F_DW) + int'(f);
            if (u % 2 != 0) begin m = m * 2; u = u - 1; end
            n  = longint'(m) << (F_DW + 2);
            rt = longint'($sqrt(real'(n)));
            while (rt * rt > n) rt--;
            while ((rt + 1) * (rt + 1) <= n) rt++;
            rm  = n - rt * rt;
            num = longint'(1) << (2 * ITER - 1);
            if (!inv) begin
                sig = rt; st = (rm != 0); ex = B + u / 2;
            end else if (rt == (longint'(1) << (ITER - 1))) begin
                sig = rt; st = 1'b0; ex = B - u / 2;
            end else begin
                sig = num / rt; st = ((num % rt) != 0); ex = B - u / 2 - 1;
            end
            mant = int'(sig / 2);
            if ((sig % 2 == 1) && (st || (mant % 2 == 1))) mant++;
            if (mant == (1 << (F_DW + 1))) begin mant = 1 << F_DW; ex++; end
            r = mk(1'b0, 8'(ex), 7'(mant - (1 << F_DW)), 1'b0, 1'b0, inv ? 2 * ITER + 2 : ITER + 2);
        end
        return r;
    endfunction

    task automatic issue(input logic s, input logic [7:0] e, input logic [6:0] f, input logic inv,
                         input exp_t x, input bit push);
        int w;
        exp_t y;
        w = 0;
        @(negedge clk);
        bus.valid_i = 1'b1; bus.s_i = s; bus.e_i = e; bus.f_i = f; bus.inv_i = inv;
        while (!bus.ready_o && w < 200) begin @(negedge clk); w++; end
        if (!bus.ready_o) begin
            check("accept_timeout", {63'd0, bus.ready_o}, 64'd1);
            bus.valid_i = 1'b0;
        end else begin
            y = x;
            y.acc = cyc + 1;
            if (push) q.push_back(y);
            @(posedge clk);
            #1 bus.valid_i = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) bus.ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    exp_t cur;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                have = 1'b0; drop_chk = 1'b0;
            end else if (drop_chk) begin
                check("valid_drop", {63'd0, bus.valid_o}, 64'd0);
                drop_chk = 1'b0;
            end else if (bus.valid_o === 1'b1) begin
                if (!have) begin
                    if (q.size() == 0) begin
                        check("unexpected_out", {63'd0, bus.valid_o}, 64'd0);
                    end else begin
                        cur  = q.pop_front();
                        have = 1'b1;
                        check("latency", 64'(cyc + 1 - cur.acc), 64'(cur.lat));
                    end
                end
                if (have) begin
                    check("s_o", {63'd0, bus.s_o}, {63'd0, cur.s});
                    check("e_o", {56'd0, bus.e_o}, {56'd0, cur.e});
                    check("f_o", {57'd0, bus.f_o}, {57'd0, cur.f});
                    check("invalid_o", {63'd0, bus.invalid_o}, {63'd0, cur.iv});
                    check("divzero_o", {63'd0, bus.divzero_o}, {63'd0, cur.dz});
                end
                if (bus.ready_i) begin have = 1'b0; drop_chk = 1'b1; end
            end
        end
    end

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || have || bus.valid_o) && w < 400) begin @(negedge clk); w++; end
        check("drain_queue", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic       rs, riv;
        logic [7:0] re;
        logic [6:0] rf;
        int         k, w;
        bus.valid_i = 1'b0; bus.inv_i = 1'b0; bus.s_i = 1'b0; bus.e_i = '0; bus.f_i = '0;
        bus.ready_i = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {63'd0, bus.ready_o}, 64'd1);
        check("rst_valid", {63'd0, bus.valid_o}, 64'd0);
        check("rst_result", {48'd0, bus.s_o, bus.e_o, bus.f_o}, 64'd0);
        check("rst_flags", {62'd0, bus.invalid_o, bus.divzero_o}, 64'd0);

        issue(1'b0, 8'd129, 7'h00, 1'b0, mk(1'b0, 8'd128, 7'h00, 1'b0, 1'b0, 11), 1'b1);
        issue(1'b0, 8'd128, 7'h00, 1'b0, mk(1'b0, 8'd127, 7'h35, 1'b0, 1'b0, 11), 1'b1);
        issue(1'b0, 8'd128, 7'h00, 1'b1, mk(1'b0, 8'd126, 7'h35, 1'b0, 1'b0, 20), 1'b1);
        issue(1'b0, 8'd129, 7'h00, 1'b1, mk(1'b0, 8'd126, 7'h00, 1'b0, 1'b0, 20), 1'b1);
        issue(1'b0, 8'd0,   7'h00, 1'b1, mk(1'b0, 8'd255, 7'h00, 1'b0, 1'b1, 2), 1'b1);
        issue(1'b1, 8'd127, 7'h00, 1'b0, mk(1'b0, 8'd255, 7'h40, 1'b1, 1'b0, 2), 1'b1);
        issue(1'b1, 8'd0,   7'h00, 1'b0, mk(1'b1, 8'd0,   7'h00, 1'b0, 1'b0, 2), 1'b1);
        issue(1'b0, 8'd255, 7'h00, 1'b1, mk(1'b0, 8'd0,   7'h00, 1'b0, 1'b0, 2), 1'b1);
        issue(1'b0, 8'd255, 7'h00, 1'b0, mk(1'b0, 8'd255, 7'h00, 1'b0, 1'b0, 2), 1'b1);
        issue(1'b0, 8'd127, 7'h00, 1'b1, mk(1'b0, 8'd127, 7'h00, 1'b0, 1'b0, 20), 1'b1);
        issue(1'b0, 8'd1,   7'h00, 1'b0, model(1'b0, 8'd1,   7'h00, 1'b0), 1'b1);
        issue(1'b0, 8'd1,   7'h00, 1'b1, model(1'b0, 8'd1,   7'h00, 1'b1), 1'b1);
        issue(1'b0, 8'd254, 7'h7F, 1'b0, model(1'b0, 8'd254, 7'h7F, 1'b0), 1'b1);
        issue(1'b0, 8'd254, 7'h7F, 1'b1, model(1'b0, 8'd254, 7'h7F, 1'b1), 1'b1);
        issue(1'b0, 8'd127, 7'h7F, 1'b1, model(1'b0, 8'd127, 7'h7F, 1'b1), 1'b1);
        drain();

        // Consumer stalls in DONE while the producer pokes valid_i.
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 bus.ready_i = 1'b0;
        issue(1'b0, 8'd128, 7'h00, 1'b0, mk(1'b0, 8'd127, 7'h35, 1'b0, 1'b0, 11), 1'b1);
        w = 0;
        while (bus.valid_o !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        check("hold_valid", {63'd0, bus.valid_o}, 64'd1);
        for (int c = 0; c < 5; c++) begin
            check("hold_ready", {63'd0, bus.ready_o}, 64'd0);
            if (c == 1) begin
                bus.valid_i = 1'b1; bus.s_i = 1'b0; bus.e_i = 8'd129; bus.f_i = 7'h00; bus.inv_i = 1'b1;
            end else begin
                bus.valid_i = 1'b0;
            end
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        @(posedge clk);
        #2 bus.ready_i = 1'b1;
        rand_rdy = 1'b1;
        drain();

        // Reset in the middle of the root recurrence discards the operation.
        issue(1'b0, 8'd129, 7'h00, 1'b0, mk(1'b0, 8'd128, 7'h00, 1'b0, 1'b0, 11), 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_valid", {63'd0, bus.valid_o}, 64'd0);
        check("abort_ready", {63'd0, bus.ready_o}, 64'd1);
        issue(1'b0, 8'd129, 7'h00, 1'b0, mk(1'b0, 8'd128, 7'h00, 1'b0, 1'b0, 11), 1'b1);
        drain();

        for (int i = 0; i < 60; i++) begin
            k   = $urandom_range(0, 9);
            rf  = 7'($urandom);
            riv = 1'($urandom);
            rs  = (k == 0);
            if (k == 1)      re = 8'd0;
            else if (k == 2) re = 8'hFF;
            else             re = 8'($urandom_range(1, 254));
            issue(rs, re, rf, riv, model(rs, re, rf, riv), 1'b1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
